dm_capture: RTL and testbench

Delta-modulation bitstream receiver and capture buffer. It accepts the 1-bit encoded stream produced by the encode path and reconstructs signed 8-bit samples by step accumulation. It smooths them with a 4-tap moving average and writes 256 filtered samples into an internal buffer. The buffer is then read back by address; the block is the receiving end of the encoded-bit link and the writer counterpart to the sample-ROM reader.

---
 rtl/dm_pkg.sv | 22 ++
 rtl/dm_mavg4.sv | 42 ++++
 rtl/dm_capture.sv | 118 +++++++++++
 tb/tb_dm_capture.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types and constants for the delta-modulation capture path.
package dm_pkg;

  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned SUM_W      = 10;
  localparam int unsigned DEF_STEP   = 1;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } dm_state_t;

  // Sign-extend a sample to the wider accumulation width.
  function automatic logic signed [SUM_W-1:0] sext_sample(input logic [SAMPLE_W-1:0] s);
    return {{(SUM_W - SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/dm_mavg4.sv
// 4-tap moving average of reconstructed samples; registered output, floor division by 4.
module dm_mavg4
  import dm_pkg::*;
(
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data
);

  logic [SAMPLE_W-1:0]     d1, d2, d3;
  logic signed [SUM_W-1:0] sum_c;
  logic [SAMPLE_W-1:0]     avg_c;

  // Sum cannot overflow 10 bits, and the floored quarter always fits in 8.
  always_comb begin
    sum_c = sext_sample(in_sample) + sext_sample(d1) + sext_sample(d2) + sext_sample(d3);
    avg_c = SAMPLE_W'(sum_c >>> 2);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset || clear) begin
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d1       <= in_sample;
        d2       <= d1;
        d3       <= d2;
        out_data <= avg_c;
      end
    end
  end

endmodule

// File: rtl/dm_capture.sv
// Delta-modulation receiver: rebuilds samples from the bit stream, filters them
// and captures DEPTH filtered words into a readable buffer.
module dm_capture
  import dm_pkg::*;
#(
  parameter int STEP   = DEF_STEP,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  input  logic                start,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic [SAMPLE_W-1:0] sample,
  output logic                sample_valid,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0]       LAST   = ADDR_W'(DEPTH - 1);
  localparam logic signed [SUM_W-1:0] STEP_W = SUM_W'(STEP);
  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-128);

  dm_state_t               state, next_state;
  logic                    arm_c, accept_c;
  logic [SAMPLE_W-1:0]     acc, acc_next_c;
  logic signed [SUM_W-1:0] acc_sum_c;
  logic [ADDR_W-1:0]       acc_cnt, wr_addr;
  logic                    filt_valid;
  logic [SAMPLE_W-1:0]     filt_data;
  logic [SAMPLE_W-1:0]     mem [DEPTH];

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    arm_c      = 1'b0;
    accept_c   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = CAPTURE;
          arm_c      = 1'b1;
        end
      end
      CAPTURE: begin
        if (bit_valid) begin
          accept_c = 1'b1;
          if (acc_cnt == LAST) next_state = DRAIN;
        end
      end
      DRAIN: begin
        // The last filtered word lands two cycles after the last accepted bit.
        if (filt_valid && wr_addr == LAST) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Saturating step accumulator.
  always_comb begin
    acc_sum_c  = sext_sample(acc) + (bit_in ? STEP_W : -STEP_W);
    acc_next_c = SAMPLE_W'(acc_sum_c);
    if (acc_sum_c > SAT_HI)      acc_next_c = SAMPLE_W'(SAT_HI);
    else if (acc_sum_c < SAT_LO) acc_next_c = SAMPLE_W'(SAT_LO);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      acc          <= '0;
      acc_cnt      <= '0;
      wr_addr      <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_data      <= '0;
    end else begin
      sample_valid <= accept_c;
      busy         <= (next_state == CAPTURE) || (next_state == DRAIN);
      done         <= (next_state == DONE);
      rd_data      <= mem[rd_addr];
      if (arm_c) begin
        acc     <= '0;
        acc_cnt <= '0;
      end else if (accept_c) begin
        acc     <= acc_next_c;
        sample  <= acc_next_c;
        acc_cnt <= acc_cnt + ADDR_W'(1);
      end
      if (arm_c)           wr_addr <= '0;
      else if (filt_valid) wr_addr <= wr_addr + ADDR_W'(1);
    end
  end

  // Simple dual-port buffer; a same-address read sees the pre-write word.
  always_ff @(posedge CLK100MHZ) begin
    if (filt_valid && !reset) mem[wr_addr] <= filt_data;
  end

  dm_mavg4 u_mavg (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .clear     (arm_c),
    .in_valid  (sample_valid),
    .in_sample (sample),
    .out_valid (filt_valid),
    .out_data  (filt_data)
  );

endmodule

// File: tb/tb_dm_capture.sv
// Self-checking bench for dm_capture: directed vector tables plus randomized
// full captures checked against a queue-based reference model.
module tb_dm_capture;

  localparam int STEP   = 1;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  localparam int M_IDLE = 0, M_CAP = 1, M_DRAIN = 2, M_DONE = 3;

  logic              CLK100MHZ = 1'b0;
  logic              reset, start, bit_in, bit_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data, sample;
  logic              sample_valid, busy, done;

  always #5 CLK100MHZ = ~CLK100MHZ;

  dm_capture #(.STEP(STEP), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK100MHZ    (CLK100MHZ),
    .reset        (reset),
    .start        (start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_st, m_acc, m_sample, m_sv, m_wr, m_age;
  int m_hist[$];
  int m_exp[DEPTH];

  typedef struct {
    logic st;
    logic b;
    logic v;
    int   exp_sample;
    int   exp_sv;
  } vec_t;

  vec_t t1[6];
  vec_t t2[4];
  int   t1_buf[4];
  int   t2_buf[3];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int floor4(input int s);
    int q;
    q = s / 4;
    if ((s % 4 != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_acc = 0; m_sample = 0; m_sv = 0; m_wr = 0; m_age = 0;
    m_hist.delete();
  endtask

  task automatic model_accept(input logic b);
    int s;
    m_acc = b ? m_acc + STEP : m_acc - STEP;
    if (m_acc > 127)  m_acc = 127;
    if (m_acc < -128) m_acc = -128;
    m_sample = m_acc;
    m_sv     = 1;
    m_hist.push_front(m_acc);
    if (m_hist.size() > 4) void'(m_hist.pop_back());
    s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    m_exp[m_wr] = floor4(s);
    m_wr++;
    if (m_wr == DEPTH) begin
      m_st  = M_DRAIN;
      m_age = 0;
    end
  endtask

  task automatic model_edge(input logic st, input logic b, input logic v);
    m_sv = 0;
    case (m_st)
      M_IDLE, M_DONE: if (st) begin
        m_st = M_CAP; m_acc = 0; m_wr = 0;
        m_hist.delete();
      end
      M_CAP: if (v) model_accept(b);
      M_DRAIN: begin
        m_age++;
        if (m_age == 2) m_st = M_DONE;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    chk("sample", int'($signed(sample)), m_sample);
    chk("sample_valid", int'(sample_valid), m_sv);
    chk("busy", int'(busy), int'(m_st == M_CAP || m_st == M_DRAIN));
    chk("done", int'(done), int'(m_st == M_DONE));
  endtask

  task automatic cycle(input logic st, input logic b, input logic v);
    start = st; bit_in = b; bit_valid = v;
    @(posedge CLK100MHZ);
    model_edge(st, b, v);
    #1;
    check_outputs();
    start = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bit_valid = 1'b0;
    @(posedge CLK100MHZ);
    model_reset();
    #1;
    reset = 1'b0;
    check_outputs();
    chk("reset_rd_data", int'($signed(rd_data)), 0);
  endtask

  task automatic rd_chk(input string nm, input int a, input int exp);
    rd_addr = ADDR_W'(a);
    cycle(1'b0, 1'b0, 1'b0);
    chk(nm, int'($signed(rd_data)), exp);
  endtask

  task automatic finish_capture();
    for (int k = 0; k < 4000 && m_st == M_CAP; k++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    chk("capture_finished", int'(m_st != M_CAP), 1);
    // Extra bits after the last accept must be ignored
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b1);
    chk("done_after_capture", int'(done), 1);
  endtask

  task automatic readback_all();
    for (int a = 0; a < DEPTH; a++) rd_chk("readback", a, m_exp[a]);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; rd_addr = '0;
    model_reset();

    t1[0] = '{1'b1, 1'b0, 1'b0, 0, 0};
    t1[1] = '{1'b0, 1'b1, 1'b1, 1, 1};
    t1[2] = '{1'b0, 1'b1, 1'b1, 2, 1};
    t1[3] = '{1'b0, 1'b1, 1'b0, 2, 0};
    t1[4] = '{1'b1, 1'b1, 1'b1, 3, 1};
    t1[5] = '{1'b0, 1'b1, 1'b1, 4, 1};
    t1_buf = '{0, 0, 1, 2};
    t2[0] = '{1'b1, 1'b0, 1'b0, 0, 0};
    t2[1] = '{1'b0, 1'b0, 1'b1, -1, 1};
    t2[2] = '{1'b0, 1'b0, 1'b1, -2, 1};
    t2[3] = '{1'b0, 1'b0, 1'b1, -3, 1};
    t2_buf = '{-1, -1, -2};

    do_reset();

    // Rising ramp, with a gap and a start pulse that must be ignored
    foreach (t1[i]) begin
      cycle(t1[i].st, t1[i].b, t1[i].v);
      chk("t1_sample", int'($signed(sample)), t1[i].exp_sample);
      chk("t1_valid", int'(sample_valid), t1[i].exp_sv);
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    foreach (t1_buf[i]) rd_chk("t1_buf", i, t1_buf[i]);

    // Abandon capture after 10 bits
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, 1'b1);
    do_reset();

    // Falling ramp after re-arm must restart at address 0
    foreach (t2[i]) begin
      cycle(t2[i].st, t2[i].b, t2[i].v);
      chk("t2_sample", int'($signed(sample)), t2[i].exp_sample);
      chk("t2_valid", int'(sample_valid), t2[i].exp_sv);
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    foreach (t2_buf[i]) rd_chk("t2_buf", i, t2_buf[i]);

    // Positive saturation then a full capture with gaps
    do_reset();
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 200; k++) cycle(1'b0, 1'b1, 1'b1);
    chk("sat_hi_sample", int'($signed(sample)), 127);
    finish_capture();
    readback_all();
    for (int a = 130; a < 200; a++) rd_chk("sat_hi_buf", a, 127);

    // Re-arm from DONE clears done; negative saturation run
    cycle(1'b1, 1'b0, 1'b0);
    chk("rearm_done", int'(done), 0);
    chk("rearm_busy", int'(busy), 1);
    for (int k = 0; k < 150; k++) cycle(1'b0, 1'b0, 1'b1);
    chk("sat_lo_sample", int'($signed(sample)), -128);
    finish_capture();
    readback_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
